// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR datapath and its sequencer.
//   LFSR_W        : LFSR register width
//   LFSR_TAP_MASK : feedback mask applied when the bit shifted out is 1
//   state_e       : sequencer states (idle, stepping, result held)
package lfsr_pkg;

  localparam int unsigned        LFSR_W        = 8;
  localparam logic [LFSR_W-1:0]  LFSR_TAP_MASK = 8'h1D;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state function of the 8-bit Galois LFSR.
// Shifts left by one and folds the outgoing MSB back through the tap mask.
// Ports:
//   cur_i : current LFSR value
//   nxt_o : LFSR value after one advance
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur_i,
  output logic [LFSR_W-1:0] nxt_o
);

  always_comb begin
    nxt_o = {cur_i[LFSR_W-2:0], 1'b0};
    if (cur_i[LFSR_W-1]) begin
      nxt_o = nxt_o ^ LFSR_TAP_MASK;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Request/response sequencer for one 8-bit Galois LFSR. A request loads a seed
// and a step count; the LFSR is advanced that many times and the final value
// is offered on the response channel until the requester takes it.
// Ports:
//   clk, res               : clock, asynchronous active-high reset
//   req_valid/req_ready    : request handshake
//   req_seed, req_steps    : seed and advance count, sampled on accept only
//   rsp_valid/rsp_ready    : response handshake
//   rsp_data               : LFSR register (final result while rsp_valid)
//   busy                   : controller is not idle
// Build option: define LFSR_ZERO_GUARD_EN to replace a zero seed with 8'h01 so
// the all-zero lock state can never be entered.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LFSR_W-1:0] req_seed,
  input  logic [STEP_W-1:0] req_steps,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LFSR_W-1:0] rsp_data,
  output logic              busy
);

  state_e              state_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [STEP_W-1:0]   cnt_q;
  logic [LFSR_W-1:0]   lfsr_nxt;
  logic [LFSR_W-1:0]   seed_eff;

  lfsr_step u_lfsr_step (
    .cur_i (lfsr_q),
    .nxt_o (lfsr_nxt)
  );

`ifdef LFSR_ZERO_GUARD_EN
  always_comb begin
    seed_eff = req_seed;
    if (req_seed == '0) begin
      seed_eff = LFSR_W'(1);
    end
  end
`else
  always_comb begin
    seed_eff = req_seed;
  end
`endif

  // Handshake outputs decode the state register only; no input-to-output path.
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign rsp_data  = lfsr_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            lfsr_q  <= seed_eff;
            cnt_q   <= req_steps;
            state_q <= (req_steps == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          lfsr_q <= lfsr_nxt;
          cnt_q  <= cnt_q - STEP_W'(1);
          // cnt_q is never zero here, so it cannot wrap.
          if (cnt_q == STEP_W'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed cases followed by random
// requests, each compared with a arithmetic model of the LFSR sequence.
module tb_lfsr_seq_ctrl;

  logic       clk;
  logic       res;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_seed;
  logic [7:0] req_steps;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_fail;

  lfsr_seq_ctrl #(
    .STEP_W (8)
  ) dut (
    .clk       (clk),
    .res       (res),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_seed  (req_seed),
    .req_steps (req_steps),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Multiply by x modulo the feedback polynomial, using plain integer arithmetic.
  function automatic logic [7:0] ref_lfsr(input logic [7:0] seed, input int n);
    int x;
    logic [7:0] r;
    x = int'(seed);
`ifdef LFSR_ZERO_GUARD_EN
    if (x == 0) x = 1;
`endif
    for (int i = 0; i < n; i++) begin
      x = x * 2;
      if (x >= 256) x = (x - 256) ^ 'h1D;
    end
    r = x[7:0];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for the result, optionally stall the
  // response for 'hold' cycles, then take it. Returns in the cycle after the
  // response handshake.
  task automatic run_req(input logic [7:0] seed, input logic [7:0] steps,
                         input int hold, input bit tie_ready);
    int budget;
    int lat;
    logic [7:0] exp;
    exp = ref_lfsr(seed, int'(steps));
    budget = 0;
    while (!req_ready && budget < 20) begin
      cycle();
      budget++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_seed  = seed;
    req_steps = steps;
    rsp_ready = tie_ready;
    cycle();
    // Inputs after the accept edge must be ignored.
    req_valid = 1'b0;
    req_seed  = 8'($urandom);
    req_steps = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      cycle();
      lat++;
    end
    check("latency", 32'(lat), 32'(steps) + 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(exp));
    check("req_ready_done", 32'(req_ready), 32'd0);
    if (!tie_ready) begin
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'b1;
        req_seed  = ~seed;
        cycle();
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", 32'(rsp_data), 32'(exp));
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    cycle();
    rsp_ready = tie_ready;
    check("req_ready_after_rsp", 32'(req_ready), 32'd1);
    check("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
    check("busy_after_rsp", 32'(busy), 32'd0);
  endtask

  initial begin
    bit saw_valid;
    n_checks  = 0;
    n_fail    = 0;
    res       = 1'b1;
    req_valid = 1'b0;
    req_seed  = 8'h00;
    req_steps = 8'h00;
    rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    #12 res = 1'b0;
    cycle();

    run_req(8'h01, 8'd1, 0, 1'b0);
    run_req(8'h01, 8'd8, 0, 1'b0);
    run_req(8'hFF, 8'd1, 0, 1'b0);
    run_req(8'hA5, 8'd0, 5, 1'b0);
    run_req(8'h80, 8'd1, 0, 1'b1);
    run_req(8'h3C, 8'd4, 0, 1'b1);  // back-to-back accept in the cycle after handshake
    rsp_ready = 1'b0;
    run_req(8'h00, 8'd3, 2, 1'b0);
    run_req(8'h01, 8'd255, 0, 1'b0);

    // Reset in the middle of a long run: outputs must return at once.
    req_valid = 1'b1;
    req_seed  = 8'h5A;
    req_steps = 8'd200;
    cycle();
    req_valid = 1'b0;
    repeat (10) cycle();
    check("run_busy", 32'(busy), 32'd1);
    #2 res = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_data", 32'(rsp_data), 32'h00);
    repeat (3) cycle();
    @(negedge clk);
    res = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 260; i++) begin
      cycle();
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("no_rsp_after_rst", 32'(saw_valid), 32'd0);

    for (int t = 0; t < 25; t++) begin
      logic [7:0] s;
      logic [7:0] n;
      s = 8'($urandom);
      n = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      run_req(s, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      rsp_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
